fft4_frame_loader: RTL
======================

Name: fft4_frame_loader

Overview:
Upstream stage of the 4-point FFT datapath. Accepts a stream of signed N-bit samples over a valid/ready handshake and packs each run of four samples into a frame. Uses ping-pong double buffering so the next frame can fill while the current one is consumed. Drives the FFT inputs f_0..f_3 from a registered bank, with a frame-level valid/ready handshake.

Parameters:
N, 8, sample width in bits; matches the FFT input width.
OVF_W, 8, width of the saturating overflow counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
s_data  input  N  signed input sample
s_valid  input  1  s_data is valid this cycle
s_ready  output  1  loader can accept a sample this cycle
s_sync  input  1  frame-alignment strobe; discards any partial frame
f_0, f_1, f_2, f_3  output  N  signed frame samples to the FFT, oldest sample on f_0
m_valid  output  1  f_0..f_3 hold a complete frame
m_ready  input  1  FFT side consumes the frame this cycle
ovf_cnt  output  OVF_W  saturating count of cycles with s_valid=1 and s_ready=0

Behaviour:
- Interface: single clock clk. rst_n is synchronous and active-low; every state register is sampled on the rising edge of clk.
- Reset (rst_n=0 at a clk edge):
  - wr_idx=0, wr_bank=0, rd_bank=0, both bank-full flags=0.
  - m_valid=0, f_0..f_3=0, ovf_cnt=0.
  - s_ready is forced to 0 while rst_n=0.
- Reset mid-operation discards all buffered and partial frames. Nothing is flushed out.
- s_ready = rst_n & ~full[wr_bank]. This is combinational from the registers only; it has no dependence on s_valid.
- Sample accept: an accept occurs when s_valid & s_ready.
  - The sample is written to bank[wr_bank][wr_idx] and wr_idx increments.
  - When wr_idx=3 is written: full[wr_bank] is set, wr_bank toggles and wr_idx wraps to 0.
- s_sync=1: wr_idx returns to 0 and the partial contents are abandoned; full flags are untouched.
  - If an accept happens in the same cycle, that sample is written at index 0 and wr_idx becomes 1.
- Output: m_valid = full[rd_bank]. f_k = bank[rd_bank][k], driven from registers.
  - Latency: m_valid rises in the cycle after the 4th sample of a frame is accepted, when that bank is rd_bank.
- Frame consume: a consume occurs when m_valid & m_ready.
  - full[rd_bank] is cleared and rd_bank toggles.
  - The next frame, if already full, is presented in the following cycle with no bubble.
- f_0..f_3 and m_valid are stable while m_valid=1 and m_ready=0.
- Simultaneous events:
  - Frame completion and a consume of the other bank in the same cycle: both take effect.
  - A consume that frees bank[wr_bank] raises s_ready in the next cycle, never the same cycle.
- Both banks full: s_ready=0. Upstream samples are held off, not dropped.
  - ovf_cnt increments for each cycle with s_valid=1 and s_ready=0.
  - ovf_cnt saturates at 2^OVF_W-1 and does not wrap.
- Arithmetic: samples are stored unmodified, N bits signed, with no extension or rounding.

Optional Feature:
Macro BITREV_EN.
- Defined: the frame is presented in bit-reversed order: f_0=x0, f_1=x2, f_2=x1, f_3=x3, where x0 is the oldest sample. This is the radix-2 decimation-in-time order for a butterfly-based FFT. Realised by remapping write addresses; no extra latency.
- Undefined: natural order, f_k=xk.
- Handshake, latency and ovf_cnt are identical in both builds.

Test Plan:
- Reset, then stream 10,-20,30,-40 back-to-back with m_ready=1 → one cycle after the 4th accept, m_valid=1 with f_0..f_3 = 10,-20,30,-40. With BITREV_EN: 10,30,-20,-40.
- m_ready=0 and stream 8 samples 1..8 → after the 8th accept s_ready=0. Raise m_ready for one cycle → frame 1,2,3,4 is consumed, next cycle shows 5,6,7,8, and s_ready returns to 1 the cycle after the consume.
- With both banks full, hold s_valid=1 for 300 cycles (OVF_W=8) → ovf_cnt=255 and holds; no sample is lost once space frees.
- Send 7,8 then pulse s_sync together with sample 100, then 101,102,103 → the frame is 100,101,102,103; 7 and 8 never appear.
- Mid-stream with one full bank and a partial frame, drive rst_n=0 for one cycle → next edge: m_valid=0, f_*=0, ovf_cnt=0, s_ready=0 during reset and 1 after. A fresh 4-sample frame then emerges correctly.
- Send -128,127,-1,0 (N=8) → the output matches bit-exactly, with no sign or width corruption.

Source files
------------

// File: rtl/fft4_frame_loader.sv
// Packs four signed samples per frame into ping-pong banks feeding the 4-point FFT inputs.
// Define BITREV_EN to present each frame in bit-reversed (radix-2 DIT) order.
module fft4_frame_loader #(
  parameter int N     = 8,
  parameter int OVF_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [N-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_sync,
  output logic signed [N-1:0] f_0,
  output logic signed [N-1:0] f_1,
  output logic signed [N-1:0] f_2,
  output logic signed [N-1:0] f_3,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [OVF_W-1:0]    ovf_cnt
);

  logic signed [N-1:0] bank [2][4];
  logic [1:0]          full;
  logic [1:0]          wr_idx;
  logic                wr_bank;
  logic                rd_bank;

  logic       accept;
  logic       consume;
  logic [1:0] wr_addr;
  logic [1:0] wr_phys;

  assign s_ready = rst_n & ~full[wr_bank];
  assign accept  = s_valid & s_ready;
  assign m_valid = full[rd_bank];
  assign consume = m_valid & m_ready;

  // A sync restarts the frame, so a coincident sample lands in slot 0.
  assign wr_addr = s_sync ? 2'd0 : wr_idx;

`ifdef BITREV_EN
  assign wr_phys = {wr_addr[0], wr_addr[1]};
`else
  assign wr_phys = wr_addr;
`endif

  assign f_0 = bank[rd_bank][0];
  assign f_1 = bank[rd_bank][1];
  assign f_2 = bank[rd_bank][2];
  assign f_3 = bank[rd_bank][3];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < 4; k++) begin
          bank[b][k] <= '0;
        end
      end
      full    <= 2'b00;
      wr_idx  <= 2'd0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      if (accept) begin
        bank[wr_bank][wr_phys] <= s_data;
        if (wr_addr == 2'd3) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          wr_idx        <= 2'd0;
        end else begin
          wr_idx <= wr_addr + 2'd1;
        end
      end else if (s_sync) begin
        wr_idx <= 2'd0;
      end

      // Completion and consume always target different banks.
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end

      if (s_valid && !s_ready && (ovf_cnt != {OVF_W{1'b1}})) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

endmodule
